mips_multicycle_exec: RTL

//  Parametrised multi-cycle executor for the MIPS subset (add/sub/and/or/slt, lw, sw, beq, j).

---
 rtl/mips_multicycle_exec.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_exec.sv
// Multi-cycle executor for a MIPS subset (add/sub/and/or/slt, lw, sw, beq, j).
// Owns the register file, data memory and PC. Instructions enter through a
// valid/ready handshake:
//   a transfer happens on a rising edge where instr_valid && instr_ready;
//   instr_ready is high only in IDLE while dbg_we is low;
//   an offer made while busy is simply not taken (valid may stay asserted).
// Completion is a registered one-cycle done pulse that coincides with the
// return to IDLE. That pulse carries the PC update and the final register write.
module mips_multicycle_exec #(
  parameter int DATA_W     = 32,
  parameter int REG_COUNT  = 32,
  parameter int DMEM_DEPTH = 64,
  parameter int PC_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              dbg_we,
  input  logic [4:0]        dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic [4:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [1:0]        class_o,
  output logic [4:0]        ctrl,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] mem_load,
  output logic [PC_W-1:0]   pc,
  output logic              done,
  output logic              illegal,
  output logic [2:0]        state
);

  localparam int AW = $clog2(DMEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t r_state, w_next;

  logic [31:0]       r_instr;
  logic [DATA_W-1:0] r_a, r_b;
  logic [DATA_W-1:0] r_rf   [REG_COUNT];
  logic [DATA_W-1:0] r_dmem [DMEM_DEPTH];

  logic [5:0]        w_op, w_funct;
  logic              w_is_r, w_is_lw, w_is_sw, w_is_beq, w_is_j, w_legal;
  logic [DATA_W-1:0] w_imm_ext, w_alu, w_rs_val, w_rt_val;
  logic [PC_W-1:0]   w_pc4, w_br_tgt, w_j_tgt;
  logic [AW-1:0]     w_dm_idx;
  logic              w_accept, w_rf_we;
  logic [4:0]        w_rf_waddr;
  logic [DATA_W-1:0] w_rf_wdata;

  assign instr_ready = (r_state == S_IDLE) && !dbg_we;
  assign w_accept    = instr_valid && instr_ready;
  assign state       = r_state;

  // Decode of the latched instruction word and derived addresses
  always_comb begin
    w_op      = r_instr[31:26];
    w_funct   = r_instr[5:0];
    w_is_r    = (w_op == 6'h00) &&
                (w_funct == 6'h20 || w_funct == 6'h22 || w_funct == 6'h24 ||
                 w_funct == 6'h25 || w_funct == 6'h2A);
    w_is_lw   = (w_op == 6'h23);
    w_is_sw   = (w_op == 6'h2B);
    w_is_beq  = (w_op == 6'h04);
    w_is_j    = (w_op == 6'h02);
    w_legal   = w_is_r || w_is_lw || w_is_sw || w_is_beq || w_is_j;
    w_imm_ext = {{(DATA_W-16){r_instr[15]}}, r_instr[15:0]};
    w_pc4     = pc + PC_W'(4);
    w_br_tgt  = w_pc4 + {{(PC_W-18){r_instr[15]}}, r_instr[15:0], 2'b00};
    w_j_tgt   = {w_pc4[PC_W-1:28], r_instr[25:0], 2'b00};
    w_dm_idx  = alu_out[AW+1:2];
  end

  // Register file read ports: index 0 and unimplemented indices read as 0
  always_comb begin
    w_rs_val  = '0;
    w_rt_val  = '0;
    dbg_rdata = '0;
    if (r_instr[25:21] != 5'd0 && 32'(r_instr[25:21]) < REG_COUNT) w_rs_val = r_rf[r_instr[25:21]];
    if (r_instr[20:16] != 5'd0 && 32'(r_instr[20:16]) < REG_COUNT) w_rt_val = r_rf[r_instr[20:16]];
    if (dbg_raddr != 5'd0 && 32'(dbg_raddr) < REG_COUNT)           dbg_rdata = r_rf[dbg_raddr];
  end

  // ALU: address add for lw/sw, compare-subtract for beq, funct op for R-type
  always_comb begin
    w_alu = '0;
    if (w_is_lw || w_is_sw) begin
      w_alu = r_a + w_imm_ext;
    end else if (w_is_beq) begin
      w_alu = r_a - r_b;
    end else begin
      case (w_funct)
        6'h20:   w_alu = r_a + r_b;
        6'h22:   w_alu = r_a - r_b;
        6'h24:   w_alu = r_a & r_b;
        6'h25:   w_alu = r_a | r_b;
        6'h2A:   w_alu = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
        default: w_alu = '0;
      endcase
    end
  end

  // Register write port: debug preload in IDLE, or the final write in WB
  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_waddr = dbg_addr;
    w_rf_wdata = dbg_wdata;
    if (r_state == S_IDLE && dbg_we) begin
      w_rf_we = 1'b1;
    end else if (r_state == S_WB) begin
      w_rf_we    = 1'b1;
      w_rf_waddr = w_is_lw ? r_instr[20:16] : r_instr[15:11];
      w_rf_wdata = w_is_lw ? mem_load : alu_out;
    end
    if (w_rf_waddr == 5'd0 || 32'(w_rf_waddr) >= REG_COUNT) w_rf_we = 1'b0;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FSM next-state: j and illegal finish in DECODE, beq in EXEC, sw in MEM
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_DECODE;
      S_DECODE: w_next = (w_is_j || !w_legal) ? S_IDLE : S_EXEC;
      S_EXEC:   w_next = w_is_beq ? S_IDLE : (w_is_r ? S_WB : S_MEM);
      S_MEM:    w_next = w_is_sw ? S_IDLE : S_WB;
      S_WB:     w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Register file storage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) r_rf[i] <= '0;
    end else if (w_rf_we) begin
      r_rf[w_rf_waddr] <= w_rf_wdata;
    end
  end

  // Datapath: instruction latch, operands, ALU/load results, dmem, PC, status
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr  <= '0;
      r_a      <= '0;
      r_b      <= '0;
      class_o  <= '0;
      ctrl     <= '0;
      alu_out  <= '0;
      mem_load <= '0;
      pc       <= '0;
      done     <= 1'b0;
      illegal  <= 1'b0;
      for (int i = 0; i < DMEM_DEPTH; i++) r_dmem[i] <= '0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) r_instr <= instr;
        S_DECODE: begin
          r_a <= w_rs_val;
          r_b <= w_rt_val;
          if (w_is_r)                    begin class_o <= 2'b00; ctrl <= 5'b10000; end
          else if (w_is_lw)              begin class_o <= 2'b01; ctrl <= 5'b11000; end
          else if (w_is_sw)              begin class_o <= 2'b01; ctrl <= 5'b00100; end
          else if (w_is_beq)             begin class_o <= 2'b10; ctrl <= 5'b00010; end
          else if (w_is_j)               begin class_o <= 2'b11; ctrl <= 5'b00001; end
          else                           begin class_o <= 2'b00; ctrl <= 5'b00000; end
          if (w_is_j) begin
            pc   <= w_j_tgt;
            done <= 1'b1;
          end else if (!w_legal) begin
            pc      <= w_pc4;
            done    <= 1'b1;
            illegal <= 1'b1;
          end
        end
        S_EXEC: begin
          alu_out <= w_alu;
          if (w_is_beq) begin
            pc   <= (r_a == r_b) ? w_br_tgt : w_pc4;
            done <= 1'b1;
          end
        end
        S_MEM: begin
          if (w_is_sw) begin
            r_dmem[w_dm_idx] <= r_b;
            pc               <= w_pc4;
            done             <= 1'b1;
          end else begin
            mem_load <= r_dmem[w_dm_idx];
          end
        end
        S_WB: begin
          pc   <= w_pc4;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
